// File: rtl/uart_tx_cfg_if.sv
// Handshake/data bundle between a word source and the configurable UART transmitter.
// The source drives the trigger and word; the transmitter returns line and status.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_trig;
  logic [DATA_BITS-1:0] uart_tx;
  logic                 rs232_tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_trig,
    output uart_tx,
    input  rs232_tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_trig,
    input  uart_tx,
    output rs232_tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stops.
// Parity bit is compiled in only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic         sclk,
  input  logic         s_rst_n,
  uart_tx_cfg_if.slave bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 accept;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);
  // busy is low exactly while in IDLE, so a trigger seen in IDLE is an accepted one
  assign accept  = (state == S_IDLE) && bus.tx_trig;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (bus.tx_trig) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:
        if (bit_end && bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:   if (bit_end && bit_cnt == STOP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered line leads nothing
  always_comb begin
    baud_cnt_d = (state == S_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
    bit_cnt_d  = bit_cnt;
    if (state_d != state)     bit_cnt_d = '0;
    else if (bit_end)         bit_cnt_d = bit_cnt + 1'b1;
    shift_d = shift;
    if (accept)                          shift_d = bus.uart_tx;
    else if (state == S_DATA && bit_end) shift_d = shift >> 1;
`ifdef UART_TX_PARITY_EN
    par_d = accept ? parity_bit(bus.uart_tx) : par_q;
`endif
    busy_d = (state_d != S_IDLE);
    done_d = (state == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = par_q;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shift    <= shift_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.rs232_tx = line_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: two instances (8N1 and 7-bit/2-stop) against a frame-table model.
// Honours UART_TX_PARITY_EN when the bundle is built with it.
module tb_uart_tx_cfg;
  localparam int BD = 16;
  localparam int NI = 2;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  int podd [NI] = '{0, 1};
`else
  localparam int P = 0;
`endif

  int dbits [NI] = '{8, 7};
  int sbits [NI] = '{1, 2};

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 sclk = ~sclk;

  logic       trig  [NI];
  logic [8:0] data  [NI];
  logic       line  [NI];
  logic       busy  [NI];
  logic       done  [NI];

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if1 ();

  assign if0.tx_trig = trig[0];
  assign if0.uart_tx = data[0][7:0];
  assign line[0]     = if0.rs232_tx;
  assign busy[0]     = if0.tx_busy;
  assign done[0]     = if0.tx_done;
  assign if1.tx_trig = trig[1];
  assign if1.uart_tx = data[1][6:0];
  assign line[1]     = if1.rs232_tx;
  assign busy[1]     = if1.tx_busy;
  assign done[1]     = if1.tx_done;

  uart_tx_cfg #(.BAUD_DIV(BD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .sclk(sclk), .s_rst_n(s_rst_n), .bus(if0));
  uart_tx_cfg #(.BAUD_DIV(BD), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .bus(if1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int i, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%b want=%b", name, i, $time, act, want);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, want);
    end
  endtask

  // Model: a frame is a bit table (start, data LSB-first, parity, stops), each bit BD cycles long
  function automatic logic [15:0] make_frame(input logic [8:0] d, input int idx);
    logic [15:0] f;
    logic par;
    int k;
    f   = '1;
    par = 1'b0;
    f[0] = 1'b0;
    k = 1;
    for (int b = 0; b < dbits[idx]; b++) begin
      f[k] = d[b];
      par  = par ^ d[b];
      k++;
    end
`ifdef UART_TX_PARITY_EN
    f[k] = par ^ (podd[idx] != 0);
`endif
    return f;
  endfunction

  int          pos      [NI] = '{-1, -1};
  int          flen     [NI] = '{0, 0};
  logic [15:0] frame    [NI];
  logic        exp_done [NI] = '{1'b0, 1'b0};

  always @(posedge sclk or negedge s_rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!s_rst_n) begin
        pos[i]      <= -1;
        exp_done[i] <= 1'b0;
      end else if (pos[i] >= 0) begin
        exp_done[i] <= (pos[i] + 1 == flen[i]);
        pos[i]      <= (pos[i] + 1 == flen[i]) ? -1 : pos[i] + 1;
      end else begin
        exp_done[i] <= 1'b0;
        if (trig[i]) begin
          pos[i]   <= 0;
          flen[i]  <= BD * (1 + dbits[i] + P + sbits[i]);
          frame[i] <= make_frame(data[i], i);
        end
      end
    end
  end

  always @(negedge sclk) begin
    for (int i = 0; i < NI; i++) begin
      chk("line", i, line[i], (pos[i] < 0) ? 1'b1 : frame[i][pos[i] / BD]);
      chk("busy", i, busy[i], pos[i] >= 0);
      chk("done", i, done[i], exp_done[i]);
    end
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < 2000) begin
      tick();
      n++;
    end
    chk("wait_idle", 0, busy[0] | busy[1], 1'b0);
  endtask

  logic s0 [16];
  logic s1 [16];
  logic exp55 [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic exp41 [8] = '{0, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    int bc0, bc1, dc0, dc1, n;
    trig[0] = 1'b0; trig[1] = 1'b0;
    data[0] = '0;   data[1] = '0;
    s_rst_n = 1'b0;
    #100 s_rst_n = 1'b1;
    repeat (10) tick();

    // Directed: 8'h55 on the 8N1 unit, 7'h41 on the 7-bit/2-stop unit, data scrambled after capture
    trig[0] = 1'b1; data[0] = 9'h055;
    trig[1] = 1'b1; data[1] = 9'h041;
    tick();
    trig[0] = 1'b0; trig[1] = 1'b0;
    bc0 = 0; bc1 = 0; dc0 = 0; dc1 = 0;
    for (int c = 0; c < BD * 16; c++) begin
      if (busy[0]) bc0++;
      if (busy[1]) bc1++;
      if (done[0]) dc0++;
      if (done[1]) dc1++;
      if (c % BD == BD / 2) begin
        s0[c / BD] = line[0];
        s1[c / BD] = line[1];
      end
      data[0] = 9'($urandom);
      data[1] = 9'($urandom);
      tick();
    end
    chk_int("busy_len0", bc0, BD * (10 + P));
    chk_int("busy_len1", bc1, BD * (10 + P));
    chk_int("done_cnt0", dc0, 1);
    chk_int("done_cnt1", dc1, 1);
    for (int k = 0; k < 9; k++) chk("bits55", k, s0[k], exp55[k]);
    for (int k = 0; k < 8; k++) chk("bits41", k, s1[k], exp41[k]);
`ifdef UART_TX_PARITY_EN
    chk("par55_even", 0, s0[9], 1'b0);
    chk("par41_odd", 1, s1[8], 1'b1);
`endif

    // Directed: 8'hA3, then a retrigger with 8'hFF 40 cycles in while busy
    wait_idle();
    trig[0] = 1'b1; data[0] = 9'h0A3;
    tick();
    trig[0] = 1'b0;
    repeat (39) tick();
    trig[0] = 1'b1; data[0] = 9'h0FF;
    tick();
    trig[0] = 1'b0;

    // Directed: trigger in the tx_done cycle gives a back-to-back frame
    n = 0;
    while (!done[0] && n < 400) begin
      tick();
      n++;
    end
    chk("done_seen", 0, done[0], 1'b1);
    trig[0] = 1'b1; data[0] = 9'h00F;
    tick();
    trig[0] = 1'b0;
    chk("b2b_start", 0, line[0], 1'b0);
    chk("b2b_busy", 0, busy[0], 1'b1);
    wait_idle();

    // Directed: reset during bit 3 of a frame, then a clean 8'h55 frame
    trig[0] = 1'b1; data[0] = 9'h055;
    trig[1] = 1'b1; data[1] = 9'h055;
    tick();
    trig[0] = 1'b0; trig[1] = 1'b0;
    repeat (3 * BD + 4) tick();
    #2 s_rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_line", i, line[i], 1'b1);
      chk("rst_busy", i, busy[i], 1'b0);
      chk("rst_done", i, done[i], 1'b0);
    end
    repeat (2) tick();
    s_rst_n = 1'b1;
    tick();
    trig[0] = 1'b1; data[0] = 9'h055;
    trig[1] = 1'b1; data[1] = 9'h055;
    tick();
    trig[0] = 1'b0; trig[1] = 1'b0;
    wait_idle();

    // Random traffic: frequent triggers when idle, rare ignored ones while busy
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (!busy[i]) trig[i] = ($urandom_range(0, 3) == 0);
        else          trig[i] = ($urandom_range(0, 63) == 0);
        data[i] = 9'($urandom);
      end
      tick();
    end
    trig[0] = 1'b0; trig[1] = 1'b0;
    wait_idle();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
